// File: rtl/control_unit_types_pkg.sv
// Control-path types shared by decode, hazard and pipeline-register blocks.
// No logic; type definitions only.
// Not applicable (no handshake).
package control_unit_types_pkg;

    // Write-back source select carried down the pipe
    typedef enum logic [1:0] {
        M2R_ALU = 2'd0,
        M2R_MEM = 2'd1,
        M2R_NPC = 2'd2,
        M2R_LUI = 2'd3
    } memtoreg_t;

    // EX/MEM data-memory request sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } exmem_state_t;

endpackage

// File: rtl/cpu_types_pkg.sv
// Shared datapath types: machine word and register-index widths.
// No logic; type definitions only.
// Not applicable (no handshake).
package cpu_types_pkg;

    localparam int WORD_W = 32;
    localparam int REG_W  = 5;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [REG_W-1:0]  regbits_t;

endpackage

// File: rtl/exmem_pipe_dmem_req_fsm.sv
// Data-memory request sequencer for the EX/MEM stage: IDLE -> REQ -> DONE.
// Request strobes assert the cycle after a latch; they drop the cycle after dhit.
// While in REQ it reports busy and ignores stall/flush until dhit arrives.
module dmem_req_fsm
    import control_unit_types_pkg::*;
(
    input  logic CLK,
    input  logic nRST,
    input  logic latch,
    input  logic req_rd,
    input  logic req_wr,
    input  logic dhit,
    output logic dmemREN,
    output logic dmemWEN,
    output logic busy,
    output logic load_hit
);

    exmem_state_t state_q, state_d;
    logic         ren_q, ren_d;
    logic         wen_q, wen_d;

    // Next-state and next-strobe selection; a combined read+write request becomes a read
    always_comb begin
        state_d = state_q;
        ren_d   = ren_q;
        wen_d   = wen_q;
        case (state_q)
            REQ: begin
                if (dhit) begin
                    state_d = DONE;
                    ren_d   = 1'b0;
                    wen_d   = 1'b0;
                end
            end
            default: begin
                if (latch) begin
                    if (req_rd || req_wr) begin
                        state_d = REQ;
                        ren_d   = req_rd;
                        wen_d   = req_wr & ~req_rd;
                    end else begin
                        state_d = IDLE;
                        ren_d   = 1'b0;
                        wen_d   = 1'b0;
                    end
                end
            end
        endcase
    end

    // State and registered strobes; reset abandons any outstanding request
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= IDLE;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ren_q   <= ren_d;
            wen_q   <= wen_d;
        end
    end

    assign dmemREN  = ren_q;
    assign dmemWEN  = wen_q;
    assign busy     = (state_q == REQ);
    assign load_hit = (state_q == REQ) & dhit & ren_q;

endmodule

// File: rtl/exmem_pipe.sv
// EX/MEM pipeline register with data-memory request handshake; EXMEM_PERF_EN adds perf counters.
// Fields update 1 cycle after a latch cycle (en=1, not busy, not halted).
// mem_busy stalls the hazard unit while a request waits for dhit; halt freezes the stage.
module exmem_pipe
    import cpu_types_pkg::*;
    import control_unit_types_pkg::*;
(
    input  logic      CLK,
    input  logic      nRST,
    input  logic      en,
    input  logic      flush,
    input  logic      ex_valid,
    input  logic      ex_RegWEN,
    input  memtoreg_t ex_MemtoReg,
    input  logic      ex_dRENi,
    input  logic      ex_dWENi,
    input  logic      ex_halt,
    input  regbits_t  ex_wsel,
    input  word_t     ex_aluout,
    input  word_t     ex_storedata,
    input  word_t     ex_npc,
    output logic      mem_valid,
    output logic      mem_RegWEN,
    output memtoreg_t mem_MemtoReg,
    output logic      mem_halt,
    output regbits_t  mem_wsel,
    output word_t     mem_aluout,
    output word_t     mem_npc,
    output word_t     mem_dload,
    output logic      dmemREN,
    output logic      dmemWEN,
    output word_t     dmemaddr,
    output word_t     dmemstore,
    input  logic      dhit,
    input  word_t     dmemload,
`ifdef EXMEM_PERF_EN
    output word_t     perf_stall,
    output word_t     perf_commit,
`endif
    output logic      mem_busy
);

    logic      valid_q, valid_d;
    logic      regwen_q, regwen_d;
    memtoreg_t m2r_q, m2r_d;
    logic      halt_q, halt_d;
    regbits_t  wsel_q, wsel_d;
    word_t     aluout_q, aluout_d;
    word_t     npc_q, npc_d;
    word_t     store_q, store_d;
    word_t     dload_q, dload_d;

    logic latch;
    logic busy;
    logic load_hit;
    logic req_rd;
    logic req_wr;

    assign latch  = en & ~busy & ~halt_q;
    assign req_rd = ex_valid & ~flush & ex_dRENi;
    assign req_wr = ex_valid & ~flush & ex_dWENi;

    dmem_req_fsm u_req_fsm (
        .CLK      (CLK),
        .nRST     (nRST),
        .latch    (latch),
        .req_rd   (req_rd),
        .req_wr   (req_wr),
        .dhit     (dhit),
        .dmemREN  (dmemREN),
        .dmemWEN  (dmemWEN),
        .busy     (busy),
        .load_hit (load_hit)
    );

    // Pipeline field update: copy EX on latch, then squash control bits on flush
    always_comb begin
        valid_d  = valid_q;
        regwen_d = regwen_q;
        m2r_d    = m2r_q;
        halt_d   = halt_q;
        wsel_d   = wsel_q;
        aluout_d = aluout_q;
        npc_d    = npc_q;
        store_d  = store_q;
        dload_d  = load_hit ? dmemload : dload_q;
        if (latch) begin
            valid_d  = ex_valid;
            regwen_d = ex_RegWEN;
            m2r_d    = ex_MemtoReg;
            halt_d   = ex_valid & ex_halt;
            wsel_d   = ex_wsel;
            aluout_d = ex_aluout;
            npc_d    = ex_npc;
            store_d  = ex_storedata;
            if (flush) begin
                valid_d  = 1'b0;
                regwen_d = 1'b0;
                halt_d   = 1'b0;
            end
        end
    end

    // Pipeline field registers; halt stays set because it blocks every later latch
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            valid_q  <= 1'b0;
            regwen_q <= 1'b0;
            m2r_q    <= M2R_ALU;
            halt_q   <= 1'b0;
            wsel_q   <= '0;
            aluout_q <= 32'h0;
            npc_q    <= 32'h0;
            store_q  <= 32'h0;
            dload_q  <= 32'h0;
        end else begin
            valid_q  <= valid_d;
            regwen_q <= regwen_d;
            m2r_q    <= m2r_d;
            halt_q   <= halt_d;
            wsel_q   <= wsel_d;
            aluout_q <= aluout_d;
            npc_q    <= npc_d;
            store_q  <= store_d;
            dload_q  <= dload_d;
        end
    end

`ifdef EXMEM_PERF_EN
    word_t stall_cnt_q, stall_cnt_d;
    word_t commit_cnt_q, commit_cnt_d;

    // Counter increments; natural 32-bit wrap
    always_comb begin
        stall_cnt_d  = stall_cnt_q  + {31'b0, (busy | ~en)};
        commit_cnt_d = commit_cnt_q + {31'b0, (latch & ex_valid & ~flush)};
    end

    // Counter registers
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            stall_cnt_q  <= 32'h0;
            commit_cnt_q <= 32'h0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            commit_cnt_q <= commit_cnt_d;
        end
    end

    assign perf_stall  = stall_cnt_q;
    assign perf_commit = commit_cnt_q;
`endif

    assign mem_valid    = valid_q;
    assign mem_RegWEN   = regwen_q;
    assign mem_MemtoReg = m2r_q;
    assign mem_halt     = halt_q;
    assign mem_wsel     = wsel_q;
    assign mem_aluout   = aluout_q;
    assign mem_npc      = npc_q;
    assign mem_dload    = dload_q;
    assign dmemaddr     = aluout_q;
    assign dmemstore    = store_q;
    assign mem_busy     = busy;

endmodule

// File: tb/tb_exmem_pipe.sv
// Directed bench for exmem_pipe: vector table for single-cycle latch/stall/flush rows,
// hand-written sequences for load, store-under-stall, reset-in-REQ, halt and perf counters.
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
module tb_exmem_pipe;
    import cpu_types_pkg::*;
    import control_unit_types_pkg::*;

    logic      CLK = 1'b0;
    logic      nRST;
    logic      en, flush;
    logic      ex_valid, ex_RegWEN, ex_dRENi, ex_dWENi, ex_halt;
    memtoreg_t ex_MemtoReg;
    regbits_t  ex_wsel;
    word_t     ex_aluout, ex_storedata, ex_npc;
    logic      mem_valid, mem_RegWEN, mem_halt;
    memtoreg_t mem_MemtoReg;
    regbits_t  mem_wsel;
    word_t     mem_aluout, mem_npc, mem_dload;
    logic      dmemREN, dmemWEN, dhit, mem_busy;
    word_t     dmemaddr, dmemstore, dmemload;
`ifdef EXMEM_PERF_EN
    word_t     perf_stall, perf_commit;
`endif

    always #5 CLK = ~CLK;

    exmem_pipe dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .en           (en),
        .flush        (flush),
        .ex_valid     (ex_valid),
        .ex_RegWEN    (ex_RegWEN),
        .ex_MemtoReg  (ex_MemtoReg),
        .ex_dRENi     (ex_dRENi),
        .ex_dWENi     (ex_dWENi),
        .ex_halt      (ex_halt),
        .ex_wsel      (ex_wsel),
        .ex_aluout    (ex_aluout),
        .ex_storedata (ex_storedata),
        .ex_npc       (ex_npc),
        .mem_valid    (mem_valid),
        .mem_RegWEN   (mem_RegWEN),
        .mem_MemtoReg (mem_MemtoReg),
        .mem_halt     (mem_halt),
        .mem_wsel     (mem_wsel),
        .mem_aluout   (mem_aluout),
        .mem_npc      (mem_npc),
        .mem_dload    (mem_dload),
        .dmemREN      (dmemREN),
        .dmemWEN      (dmemWEN),
        .dmemaddr     (dmemaddr),
        .dmemstore    (dmemstore),
        .dhit         (dhit),
        .dmemload     (dmemload),
`ifdef EXMEM_PERF_EN
        .perf_stall   (perf_stall),
        .perf_commit  (perf_commit),
`endif
        .mem_busy     (mem_busy)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic bubble();
        ex_valid     = 1'b0;
        ex_RegWEN    = 1'b0;
        ex_MemtoReg  = M2R_ALU;
        ex_dRENi     = 1'b0;
        ex_dWENi     = 1'b0;
        ex_halt      = 1'b0;
        ex_wsel      = '0;
        ex_aluout    = 32'h0;
        ex_storedata = 32'h0;
        ex_npc       = 32'h0;
    endtask

    task automatic rand_inputs();
        en           = 1'($urandom);
        flush        = 1'($urandom);
        ex_valid     = 1'($urandom);
        ex_RegWEN    = 1'($urandom);
        ex_MemtoReg  = memtoreg_t'($urandom_range(0, 3));
        ex_dRENi     = 1'($urandom);
        ex_dWENi     = 1'($urandom);
        ex_halt      = 1'($urandom);
        ex_wsel      = 5'($urandom);
        ex_aluout    = $urandom;
        ex_storedata = $urandom;
        ex_npc       = $urandom;
        dhit         = 1'($urandom);
        dmemload     = $urandom;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        rand_inputs();
        tick();
        rand_inputs();
        tick();
        nRST  = 1'b1;
        en    = 1'b1;
        flush = 1'b0;
        dhit  = 1'b0;
        bubble();
    endtask

    typedef struct {
        logic      v, rw;
        memtoreg_t m2r;
        logic [4:0] ws;
        logic [31:0] alu, npc;
        logic      en, fl, cd;
        logic      ev, erw;
        memtoreg_t em2r;
        logic [4:0] ews;
        logic [31:0] ealu, enpc;
    } vec_t;

    vec_t tbl [8];

    initial begin
        // v rw m2r ws alu npc en fl check_data | exp v rw m2r ws alu npc
        tbl[0] = '{1'b1, 1'b1, M2R_ALU, 5'd3,  32'h0000_1234, 32'h4,  1'b1, 1'b0, 1'b1,
                   1'b1, 1'b1, M2R_ALU, 5'd3,  32'h0000_1234, 32'h4};
        tbl[1] = '{1'b1, 1'b0, M2R_NPC, 5'd7,  32'hFFFF_FFFF, 32'h8,  1'b1, 1'b0, 1'b1,
                   1'b1, 1'b0, M2R_NPC, 5'd7,  32'hFFFF_FFFF, 32'h8};
        tbl[2] = '{1'b1, 1'b1, M2R_LUI, 5'd31, 32'hA5A5_0000, 32'hC,  1'b0, 1'b0, 1'b1,
                   1'b1, 1'b0, M2R_NPC, 5'd7,  32'hFFFF_FFFF, 32'h8};
        tbl[3] = '{1'b1, 1'b1, M2R_MEM, 5'd31, 32'hA5A5_0000, 32'hC,  1'b1, 1'b1, 1'b0,
                   1'b0, 1'b0, M2R_ALU, 5'd0,  32'h0,         32'h0};
        tbl[4] = '{1'b0, 1'b1, M2R_MEM, 5'd12, 32'h0000_0010, 32'h10, 1'b1, 1'b0, 1'b1,
                   1'b0, 1'b1, M2R_MEM, 5'd12, 32'h0000_0010, 32'h10};
        tbl[5] = '{1'b1, 1'b1, M2R_ALU, 5'd1,  32'h0,         32'h14, 1'b1, 1'b0, 1'b1,
                   1'b1, 1'b1, M2R_ALU, 5'd1,  32'h0,         32'h14};
        tbl[6] = '{1'b1, 1'b1, M2R_LUI, 5'd2,  32'h3,         32'h18, 1'b0, 1'b1, 1'b1,
                   1'b1, 1'b1, M2R_ALU, 5'd1,  32'h0,         32'h14};
        tbl[7] = '{1'b1, 1'b1, M2R_LUI, 5'd2,  32'h3,         32'h18, 1'b1, 1'b0, 1'b1,
                   1'b1, 1'b1, M2R_LUI, 5'd2,  32'h3,         32'h18};

        // ---- reset with random inputs ----
        nRST = 1'b0;
        rand_inputs();
        tick();
        rand_inputs();
        tick();
        chk("rst_valid",   32'(mem_valid),    32'h0);
        chk("rst_regwen",  32'(mem_RegWEN),   32'h0);
        chk("rst_m2r",     32'(mem_MemtoReg), 32'h0);
        chk("rst_halt",    32'(mem_halt),     32'h0);
        chk("rst_wsel",    32'(mem_wsel),     32'h0);
        chk("rst_aluout",  mem_aluout,        32'h0);
        chk("rst_npc",     mem_npc,           32'h0);
        chk("rst_dload",   mem_dload,         32'h0);
        chk("rst_ren",     32'(dmemREN),      32'h0);
        chk("rst_wen",     32'(dmemWEN),      32'h0);
        chk("rst_addr",    dmemaddr,          32'h0);
        chk("rst_store",   dmemstore,         32'h0);
        chk("rst_busy",    32'(mem_busy),     32'h0);
        nRST  = 1'b1;
        en    = 1'b1;
        flush = 1'b0;
        dhit  = 1'b0;
        bubble();

        // ---- table: latch / stall / flush rows ----
        for (int i = 0; i < 8; i++) begin
            ex_valid    = tbl[i].v;
            ex_RegWEN   = tbl[i].rw;
            ex_MemtoReg = tbl[i].m2r;
            ex_wsel     = tbl[i].ws;
            ex_aluout   = tbl[i].alu;
            ex_npc      = tbl[i].npc;
            en          = tbl[i].en;
            flush       = tbl[i].fl;
            tick();
            chk($sformatf("vec%0d_valid", i),  32'(mem_valid),  32'(tbl[i].ev));
            chk($sformatf("vec%0d_regwen", i), 32'(mem_RegWEN), 32'(tbl[i].erw));
            chk($sformatf("vec%0d_busy", i),   32'(mem_busy),   32'h0);
            chk($sformatf("vec%0d_halt", i),   32'(mem_halt),   32'h0);
            if (tbl[i].cd) begin
                chk($sformatf("vec%0d_m2r", i),  32'(mem_MemtoReg), 32'(tbl[i].em2r));
                chk($sformatf("vec%0d_wsel", i), 32'(mem_wsel),     32'(tbl[i].ews));
                chk($sformatf("vec%0d_alu", i),  mem_aluout,        tbl[i].ealu);
                chk($sformatf("vec%0d_npc", i),  mem_npc,           tbl[i].enpc);
            end
        end
        en    = 1'b1;
        flush = 1'b0;

        // ---- load with dhit on the third request cycle ----
        bubble();
        ex_valid    = 1'b1;
        ex_RegWEN   = 1'b1;
        ex_MemtoReg = M2R_MEM;
        ex_dRENi    = 1'b1;
        ex_wsel     = 5'd5;
        ex_aluout   = 32'h40;
        tick();
        bubble();
        for (int c = 0; c < 3; c++) begin
            if (c == 2) begin
                dhit     = 1'b1;
                dmemload = 32'hCAFE_F00D;
            end
            chk($sformatf("ld_ren_c%0d", c),  32'(dmemREN),  32'h1);
            chk($sformatf("ld_wen_c%0d", c),  32'(dmemWEN),  32'h0);
            chk($sformatf("ld_addr_c%0d", c), dmemaddr,      32'h40);
            chk($sformatf("ld_busy_c%0d", c), 32'(mem_busy), 32'h1);
            if (c < 2) tick();
        end
        tick();
        dhit     = 1'b0;
        dmemload = 32'h0;
        chk("ld_busy_after", 32'(mem_busy),  32'h0);
        chk("ld_ren_after",  32'(dmemREN),   32'h0);
        chk("ld_dload",      mem_dload,      32'hCAFE_F00D);
        chk("ld_wsel_held",  32'(mem_wsel),  32'd5);
        tick();
        chk("ld_dload_hold", mem_dload,      32'hCAFE_F00D);
        chk("ld_valid_bub",  32'(mem_valid), 32'h0);

        // ---- store held through stall and flush until dhit ----
        bubble();
        ex_valid     = 1'b1;
        ex_dWENi     = 1'b1;
        ex_aluout    = 32'h80;
        ex_storedata = 32'hDEAD_BEEF;
        tick();
        chk("st_wen",   32'(dmemWEN), 32'h1);
        chk("st_addr",  dmemaddr,     32'h80);
        chk("st_store", dmemstore,    32'hDEAD_BEEF);
        bubble();
        ex_valid  = 1'b1;
        ex_RegWEN = 1'b1;
        ex_wsel   = 5'd7;
        ex_aluout = 32'h99;
        en        = 1'b0;
        flush     = 1'b1;
        tick();
        chk("st_wen_stall",  32'(dmemWEN),   32'h1);
        chk("st_alu_stall",  mem_aluout,     32'h80);
        chk("st_valid_held", 32'(mem_valid), 32'h1);
        en = 1'b1;
        tick();
        chk("st_wen_busy",   32'(dmemWEN),   32'h1);
        chk("st_alu_busy",   mem_aluout,     32'h80);
        chk("st_valid_busy", 32'(mem_valid), 32'h1);
        dhit = 1'b1;
        tick();
        dhit = 1'b0;
        chk("st_wen_done",  32'(dmemWEN),   32'h0);
        chk("st_busy_done", 32'(mem_busy),  32'h0);
        chk("st_alu_done",  mem_aluout,     32'h80);
        chk("st_valid_done",32'(mem_valid), 32'h1);
        tick();
        chk("st_flush_valid",  32'(mem_valid),  32'h0);
        chk("st_flush_regwen", 32'(mem_RegWEN), 32'h0);
        chk("st_flush_wen",    32'(dmemWEN),    32'h0);
        flush = 1'b0;
        bubble();
        tick();

        // ---- read+write together issues only a read ----
        ex_valid  = 1'b1;
        ex_dRENi  = 1'b1;
        ex_dWENi  = 1'b1;
        ex_aluout = 32'h44;
        tick();
        bubble();
        chk("rw_ren", 32'(dmemREN), 32'h1);
        chk("rw_wen", 32'(dmemWEN), 32'h0);

        // ---- reset while in REQ abandons the request ----
        nRST = 1'b0;
        tick();
        chk("rstreq_ren",  32'(dmemREN),  32'h0);
        chk("rstreq_busy", 32'(mem_busy), 32'h0);
        nRST = 1'b1;
        tick();
        chk("rstreq_ren_next", 32'(dmemREN), 32'h0);

`ifdef EXMEM_PERF_EN
        // ---- perf counters: 4 ALU ops + 1 load with 2-cycle dhit ----
        do_reset();
        for (int k = 0; k < 4; k++) begin
            ex_valid  = 1'b1;
            ex_RegWEN = 1'b1;
            ex_wsel   = 5'(k + 1);
            ex_aluout = 32'(k);
            tick();
        end
        bubble();
        ex_valid = 1'b1;
        ex_dRENi = 1'b1;
        ex_aluout = 32'h60;
        tick();
        bubble();
        tick();
        dhit     = 1'b1;
        dmemload = 32'h1111_2222;
        tick();
        dhit = 1'b0;
        chk("perf_commit", perf_commit, 32'd5);
        chk("perf_stall",  perf_stall,  32'd2);
`endif

        // ---- halt is sticky and freezes the fields ----
        do_reset();
        ex_valid  = 1'b1;
        ex_halt   = 1'b1;
        ex_wsel   = 5'd4;
        ex_aluout = 32'h77;
        tick();
        chk("halt_set", 32'(mem_halt), 32'h1);
        bubble();
        ex_valid  = 1'b1;
        ex_RegWEN = 1'b1;
        ex_wsel   = 5'd9;
        ex_aluout = 32'h5555;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk($sformatf("halt_c%0d", c),     32'(mem_halt), 32'h1);
            chk($sformatf("halt_alu_c%0d", c), mem_aluout,    32'h77);
            chk($sformatf("halt_ws_c%0d", c),  32'(mem_wsel), 32'd4);
        end
        nRST = 1'b0;
        tick();
        chk("halt_cleared", 32'(mem_halt), 32'h0);
        nRST = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
